// File: rtl/inst_loader_pkg.sv
// Shared state encoding, frame constants and the length-range helper for inst_loader.
// Define LOADER_CHECKSUM_EN to add the CHK state (trailing XOR checksum byte).
package inst_loader_pkg;

  localparam int LEN_BYTES  = 2;
  localparam int WORD_BYTES = 4;
  localparam int LEN_W      = 8 * LEN_BYTES;

  typedef enum logic [2:0] {
    LEN_HI = 3'd0,
    LEN_LO = 3'd1,
    DATA   = 3'd2,
`ifdef LOADER_CHECKSUM_EN
    CHK    = 3'd3,
`endif
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_t;

  // True when a frame announces more words than a 2^addr_w deep memory holds.
  function automatic logic len_overflow(input logic [LEN_W-1:0] len, input int addr_w);
    logic [LEN_W:0] depth;
    if (addr_w >= LEN_W) return 1'b0;
    depth         = '0;
    depth[addr_w] = 1'b1;
    return {1'b0, len} > depth;
  endfunction

endpackage

// File: rtl/inst_loader_asm.sv
// Byte-to-word assembler: shifts bytes in big-endian order and pulses
// word_valid for one cycle after the 4th byte of each word.
module inst_loader_asm
  import inst_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        shift_en,
  input  logic [7:0]  in_byte,
  output logic        byte_last,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0] byte_idx;

  assign byte_last = (byte_idx == 2'(WORD_BYTES - 1));

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst) begin
      byte_idx   <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= shift_en && byte_last;
      if (shift_en) byte_idx <= byte_idx + 2'd1;
    end
  end

  // NOTE: the shift register is pure datapath and carries no reset; it is only
  // observed while word_valid is high, which the controlled byte index gates.
  always_ff @(posedge clk) begin
    if (shift_en) word <= {word[23:0], in_byte};
  end

endmodule

// File: rtl/inst_loader.sv
// Boot-time instruction loader: receives a length-prefixed byte frame, writes
// the words into instruction memory and releases the CPU reset when complete.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

`ifdef LOADER_CHECKSUM_EN
  localparam state_t AFTER_DATA = CHK;
`else
  localparam state_t AFTER_DATA = DONE;
`endif

  state_t            state, state_next;
  logic [7:0]        len_hi;
  logic [LEN_W-1:0]  len_full;
  logic [LEN_W-1:0]  word_cnt;
  logic [LEN_W-1:0]  words_rx;
  logic [ADDR_W-1:0] addr_cnt;
  logic              accept;
  logic              xfer;
  logic              data_xfer;
  logic              final_byte;
  logic              byte_last;
  logic              word_valid;
  logic [31:0]       word;
  logic              done_q, err_q;
  logic              done_set, err_set;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum;
  logic              csum_ok;
`endif

  assign len_full   = {len_hi, in_data};
  assign in_ready   = rst && accept;
  assign xfer       = in_valid && in_ready;
  assign data_xfer  = xfer && (state == DATA);
  assign final_byte = byte_last && (words_rx == word_cnt - LEN_W'(1));

  inst_loader_asm u_asm (
    .clk        (clk),
    .rst        (rst),
    .shift_en   (data_xfer),
    .in_byte    (in_data),
    .byte_last  (byte_last),
    .word_valid (word_valid),
    .word       (word)
  );

  always_comb begin
    accept = 1'b0;
    case (state)
      LEN_HI, LEN_LO, DATA: accept = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      CHK:                  accept = 1'b1;
`endif
      default:              accept = 1'b0;
    endcase
  end

  // NOTE: every output of this block is given a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    done_set   = 1'b0;
    err_set    = 1'b0;
    case (state)
      LEN_HI: if (xfer) state_next = LEN_LO;
      LEN_LO: begin
        if (xfer) begin
          if (len_overflow(len_full, ADDR_W)) begin
            state_next = ERR;
            err_set    = 1'b1;
          end else if (len_full == '0) begin
            state_next = AFTER_DATA;
`ifndef LOADER_CHECKSUM_EN
            done_set   = 1'b1;
`endif
          end else begin
            state_next = DATA;
          end
        end
      end
      DATA: if (xfer && final_byte) state_next = AFTER_DATA;
`ifdef LOADER_CHECKSUM_EN
      CHK: begin
        if (xfer) begin
          done_set = 1'b1;
          if (csum_ok) begin
            state_next = DONE;
          end else begin
            state_next = ERR;
            err_set    = 1'b1;
          end
        end
      end
`endif
      // The last word's write strobe fires during the first DONE cycle, so
      // done follows it by one cycle.
      DONE:    done_set = 1'b1;
      default: state_next = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= LEN_HI;
      len_hi   <= '0;
      word_cnt <= '0;
      words_rx <= '0;
      addr_cnt <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state <= state_next;
      if (xfer && (state == LEN_HI)) len_hi <= in_data;
      if (xfer && (state == LEN_LO)) word_cnt <= len_full;
      if (data_xfer && byte_last)    words_rx <= words_rx + LEN_W'(1);
      if (mem_we)                    addr_cnt <= addr_cnt + ADDR_W'(1);
      if (done_set)                  done_q   <= 1'b1;
      if (err_set)                   err_q    <= 1'b1;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  assign csum_ok = (in_data == csum);

  always_ff @(posedge clk) begin
    if (!rst) begin
      csum <= '0;
    end else if (data_xfer) begin
      csum <= csum ^ in_data;
    end
  end
`endif

  // Gating with rst keeps a word completed just before reset from being written.
  assign mem_we    = word_valid && rst;
  assign mem_addr  = addr_cnt;
  assign mem_wdata = word;
  assign done      = done_q;
  assign err       = err_q;
  assign cpu_rst   = !(done_q && !err_q);

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: directed frames plus random frames with
// random idle gaps, compared against a frame-level reference model.
module tb_inst_loader;

  localparam int AW = 10;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int          cyc;
    int          addr;
    logic [31:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_rst;
  logic          done;
  logic          err;

  int  n_checks = 0;
  int  n_pass   = 0;
  int  ncyc     = 0;
  int  done_cyc = -1;
  wr_t wq[$];

  inst_loader #(.ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_rst   (cpu_rst),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Monitor: cycle numbering, observed writes and the first cycle done is high.
  always @(negedge clk) begin
    ncyc++;
    if (mem_we) wq.push_back('{ncyc, int'(mem_addr), mem_wdata});
    if (done && done_cyc < 0) done_cyc = ncyc;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic bq_t with_chk(input bq_t b);
    bq_t r;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] x;
`endif
    r = b;
`ifdef LOADER_CHECKSUM_EN
    x = 8'h00;
    for (int i = 2; i < b.size(); i++) x ^= b[i];
    r.push_back(x);
`endif
    return r;
  endfunction

  function automatic bq_t rand_frame(input int n);
    bq_t r;
    r.push_back(8'(n >> 8));
    r.push_back(8'(n));
    if (n > (1 << AW)) return r;
    for (int i = 0; i < 4 * n; i++) r.push_back(8'($urandom));
    return with_chk(r);
  endfunction

  task automatic do_reset();
    in_valid = 1'b0;
    rst      = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Sends bytes back to back (gap >= 0) or with random 0..2 idle cycles (gap < 0);
  // xc receives the cycle number in which each byte transferred.
  task automatic drive_frame(input bq_t b, input int gap, output int xc[$], output bit ok);
    ok = 1'b1;
    xc.delete();
    foreach (b[i]) begin
      int g;
      bit acc;
      bit rdy;
      acc      = 1'b0;
      in_valid = 1'b1;
      in_data  = b[i];
      for (int t = 0; t < 40 && !acc; t++) begin
        @(negedge clk);
        rdy = in_ready;
        @(posedge clk);
        if (rdy) begin
          acc = 1'b1;
          xc.push_back(ncyc);
        end
      end
      #1 in_valid = 1'b0;
      if (!acc) begin
        check("byte_accept_timeout", 64'd0, 64'd1);
        ok = 1'b0;
        return;
      end
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      repeat (g) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  // Reference model: derives the expected writes, flags and done timing from the frame bytes.
  task automatic check_frame(input string name, input bq_t b, input int xc[$]);
    int         n;
    bit         exp_done, exp_err;
    int         exp_done_cyc;
    logic [7:0] cs;
    n        = int'({b[0], b[1]});
    exp_err  = n > (1 << AW);
    exp_done = !exp_err;
    if (exp_err) begin
      check({name, "/nwr"}, 64'(wq.size()), 64'd0);
    end else begin
      check({name, "/nwr"}, 64'(wq.size()), 64'(n));
      for (int w = 0; w < n && w < wq.size(); w++) begin
        logic [31:0] wd;
        wd = {b[2 + 4*w], b[3 + 4*w], b[4 + 4*w], b[5 + 4*w]};
        check($sformatf("%s/addr%0d", name, w), 64'(wq[w].addr), 64'(w));
        check($sformatf("%s/data%0d", name, w), 64'(wq[w].data), 64'(wd));
        check($sformatf("%s/wcyc%0d", name, w), 64'(wq[w].cyc), 64'(xc[4*w + 5] + 1));
      end
      exp_done_cyc = (n > 0) ? xc[4*n + 1] + 2 : xc[1] + 1;
`ifdef LOADER_CHECKSUM_EN
      cs = 8'h00;
      for (int i = 2; i < 4*n + 2; i++) cs ^= b[i];
      exp_err = (b[4*n + 2] != cs);
      if (xc[4*n + 2] + 1 > exp_done_cyc) exp_done_cyc = xc[4*n + 2] + 1;
`else
      cs = 8'h00;
`endif
      check({name, "/done_cyc"}, 64'(done_cyc), 64'(exp_done_cyc));
    end
    check({name, "/done"},     64'(done),     64'(exp_done));
    check({name, "/err"},      64'(err),      64'(exp_err));
    check({name, "/cpu_rst"},  64'(cpu_rst),  64'(!(exp_done && !exp_err)));
    check({name, "/in_ready"}, 64'(in_ready), 64'd0);
  endtask

  task automatic scenario(input string name, input bq_t b, input int gap);
    int xc[$];
    bit ok;
    do_reset();
    wq.delete();
    done_cyc = -1;
    drive_frame(b, gap, xc, ok);
    repeat (8) @(posedge clk);
    #1;
    if (ok) check_frame(name, b, xc);
  endtask

  initial begin
    bq_t         base, f, part;
    logic [79:0] lit;
    int          xc[$];
    bit          ok;
    int          n;

    lit = 80'h0002_3401_1100_3421_0020;
    for (int i = 9; i >= 0; i--) base.push_back(lit[8*i +: 8]);

    // Reset state observed while rst is still low.
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst/in_ready", 64'(in_ready), 64'd0);
    check("rst/mem_we",   64'(mem_we),   64'd0);
    check("rst/done",     64'(done),     64'd0);
    check("rst/err",      64'(err),      64'd0);
    check("rst/cpu_rst",  64'(cpu_rst),  64'd1);
    rst = 1'b1;
    #1 check("idle/in_ready", 64'(in_ready), 64'd1);

    scenario("basic", with_chk(base), 0);
    if (wq.size() == 2) begin
      check("basic/word0", 64'(wq[0].data), 64'h3401_1100);
      check("basic/word1", 64'(wq[1].data), 64'h3421_0020);
    end else begin
      check("basic/count", 64'(wq.size()), 64'd2);
    end

    scenario("gaps", with_chk(base), 3);

    f.delete();
    f.push_back(8'h00);
    f.push_back(8'h00);
    scenario("empty", with_chk(f), 0);

    f.delete();
    f.push_back(8'h04);
    f.push_back(8'h01);
    scenario("ovf", f, 0);
    check("ovf/done_stays_low", 64'(done_cyc), 64'hFFFF_FFFF_FFFF_FFFF);

    scenario("max_depth", rand_frame(1 << AW), 0);

    // Reset after the 6th byte: the completed first word must never be written.
    do_reset();
    wq.delete();
    done_cyc = -1;
    part = base[0:5];
    drive_frame(part, 0, xc, ok);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("abort/in_ready", 64'(in_ready), 64'd0);
    check("abort/mem_we",   64'(mem_we),   64'd0);
    check("abort/cpu_rst",  64'(cpu_rst),  64'd1);
    rst = 1'b1;
    f = with_chk(base);
    drive_frame(f, 0, xc, ok);
    repeat (8) @(posedge clk);
    #1;
    if (ok) check_frame("abort", f, xc);
    if (wq.size() > 0) check("abort/word0", 64'(wq[0].data), 64'h3401_1100);

    for (int i = 0; i < 20; i++) begin
      n = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1025, 65535))
                                      : int'($urandom_range(0, 6));
      scenario($sformatf("rnd%0d", i), rand_frame(n), -1);
    end

`ifdef LOADER_CHECKSUM_EN
    f = with_chk(base);
    f[f.size() - 1] = f[f.size() - 1] ^ 8'h01;
    scenario("bad_chk", f, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
